// File: rtl/arcino_wb_pkg.sv
// Shared types and helpers for the arcino register-file writeback slice.
// Optional forwarding is enabled by defining ARCINO_WB_FWD_EN.
package arcino_wb_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  // RV32E only has 16 registers, so address bit 4 is ignored there.
  function automatic reg_addr_t addr_mask(input bit rv32e, input reg_addr_t addr);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/arcino_rf_writeback_if.sv
// ALU and LSU result channels into the writeback stage (valid/ready handshakes).
// Used by arcino_rf_writeback; ARCINO_WB_FWD_EN does not change this interface.
interface arcino_rf_writeback_if #(
  parameter int DataWidth = 32
);
  import arcino_wb_pkg::*;

  logic                 alu_valid_i;
  logic                 alu_ready_o;
  reg_addr_t            alu_rd_i;
  logic [DataWidth-1:0] alu_wdata_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  reg_addr_t            lsu_rd_i;
  logic [DataWidth-1:0] lsu_rdata_i;

  modport master (
    output alu_valid_i, alu_rd_i, alu_wdata_i,
    output lsu_valid_i, lsu_rd_i, lsu_rdata_i,
    input  alu_ready_o, lsu_ready_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_wdata_i,
    input  lsu_valid_i, lsu_rd_i, lsu_rdata_i,
    output alu_ready_o, lsu_ready_o
  );
endinterface

// File: rtl/arcino_wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on
// load writeback, with a sticky protocol error and three busy lookups.
module arcino_wb_scoreboard #(
  parameter int NUM_WORDS = 32,
  parameter int AW        = $clog2(NUM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] look_a_i,
  input  logic [AW-1:0] look_b_i,
  input  logic [AW-1:0] look_c_i,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          busy_c_o,
  output logic          err_o
);

  logic [NUM_WORDS-1:0] sb_q, sb_d;
  logic                 set_dup, clr_idle;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_addr_i] = 1'b0;
    if (set_i && set_addr_i != '0) sb_d[set_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign set_dup  = set_i && set_addr_i != '0 && sb_q[set_addr_i] &&
                    !(clr_i && clr_addr_i == set_addr_i);
  assign clr_idle = clr_i && clr_addr_i != '0 && !sb_q[clr_addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q  <= '0;
      err_o <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      err_o <= err_o | set_dup | clr_idle;
    end
  end

  assign busy_a_o = sb_q[look_a_i];
  assign busy_b_o = sb_q[look_b_i];
  assign busy_c_o = sb_q[look_c_i];

endmodule

// File: rtl/arcino_rf_writeback.sv
// Register-file write-side master: LSU-priority arbitration onto the single RF
// write port plus load scoreboard hazards. ARCINO_WB_FWD_EN adds write-port forwarding.
module arcino_rf_writeback
  import arcino_wb_pkg::*;
#(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  arcino_rf_writeback_if.slave wb,
  input  logic                 ld_issue_i,
  input  reg_addr_t            ld_issue_rd_i,
  input  reg_addr_t            raddr_a_i,
  input  reg_addr_t            raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output reg_addr_t            rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 sb_err_o
`ifdef ARCINO_WB_FWD_EN
  ,
  output logic                 fwd_valid_a_o,
  output logic                 fwd_valid_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o
`endif
);

  localparam int  NUM_WORDS = RV32E ? 16 : 32;
  localparam int  AW        = RV32E ? 4 : 5;
`ifdef ARCINO_WB_FWD_EN
  localparam bit  FWD       = 1'b1;
`else
  localparam bit  FWD       = 1'b0;
`endif

  reg_addr_t alu_rd_m, lsu_rd_m, ld_rd_m, ra_m, rb_m;
  logic      lsu_acc, alu_acc, alu_busy, clr_hit;
  logic      busy_a, busy_b;
  wb_src_e   src;

  assign alu_rd_m = addr_mask(RV32E, wb.alu_rd_i);
  assign lsu_rd_m = addr_mask(RV32E, wb.lsu_rd_i);
  assign ld_rd_m  = addr_mask(RV32E, ld_issue_rd_i);
  assign ra_m     = addr_mask(RV32E, raddr_a_i);
  assign rb_m     = addr_mask(RV32E, raddr_b_i);

  // LSU always wins; ALU also waits while its rd has a load in flight (WAW).
  assign wb.lsu_ready_o = !rst_i;
  assign lsu_acc        = wb.lsu_valid_i && wb.lsu_ready_o;
  assign clr_hit        = lsu_acc && lsu_rd_m == alu_rd_m;
  assign wb.alu_ready_o = !rst_i && !wb.lsu_valid_i && !(alu_busy && !clr_hit);
  assign alu_acc        = wb.alu_valid_i && wb.alu_ready_o;

  always_comb begin
    src = WB_NONE;
    if (lsu_acc)      src = WB_LSU;
    else if (alu_acc) src = WB_ALU;
  end

  arcino_wb_scoreboard #(.NUM_WORDS(NUM_WORDS)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (ld_issue_i),
    .set_addr_i (ld_rd_m[AW-1:0]),
    .clr_i      (lsu_acc),
    .clr_addr_i (lsu_rd_m[AW-1:0]),
    .look_a_i   (ra_m[AW-1:0]),
    .look_b_i   (rb_m[AW-1:0]),
    .look_c_i   (alu_rd_m[AW-1:0]),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_c_o   (alu_busy),
    .err_o      (sb_err_o)
  );

  // Writes to x0 are consumed without touching the write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= 1'b0;
      case (src)
        WB_LSU: if (lsu_rd_m != '0) begin
          rf_we_o    <= 1'b1;
          rf_waddr_o <= lsu_rd_m;
          rf_wdata_o <= wb.lsu_rdata_i;
        end
        WB_ALU: if (alu_rd_m != '0) begin
          rf_we_o    <= 1'b1;
          rf_waddr_o <= alu_rd_m;
          rf_wdata_o <= wb.alu_wdata_i;
        end
        default: ;
      endcase
    end
  end

  // A write sitting on the port is not yet readable from the RF.
  assign hazard_a_o = ra_m != '0 &&
                      (busy_a || (!FWD && rf_we_o && rf_waddr_o == ra_m));
  assign hazard_b_o = rb_m != '0 &&
                      (busy_b || (!FWD && rf_we_o && rf_waddr_o == rb_m));

`ifdef ARCINO_WB_FWD_EN
  assign fwd_valid_a_o = rf_we_o && rf_waddr_o == ra_m && ra_m != '0;
  assign fwd_valid_b_o = rf_we_o && rf_waddr_o == rb_m && rb_m != '0;
  assign fwd_data_a_o  = fwd_valid_a_o ? rf_wdata_o : '0;
  assign fwd_data_b_o  = fwd_valid_b_o ? rf_wdata_o : '0;
`endif

endmodule

// File: tb/tb_arcino_rf_writeback.sv
// Directed table-driven bench for arcino_rf_writeback, plus hand sequences for
// forwarding, scoreboard error and mid-operation reset.
module tb_arcino_rf_writeback;
  import arcino_wb_pkg::*;

`ifdef ARCINO_WB_FWD_EN
  localparam bit NF = 1'b0;
`else
  localparam bit NF = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_issue;
  reg_addr_t   ld_rd, ra, rb, waddr;
  logic        hz_a, hz_b, we, err;
  logic [31:0] wdata;
`ifdef ARCINO_WB_FWD_EN
  logic        fv_a, fv_b;
  logic [31:0] fd_a, fd_b;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arcino_rf_writeback_if #(.DataWidth(32)) bus ();

  arcino_rf_writeback #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wb            (bus.slave),
    .ld_issue_i    (ld_issue),
    .ld_issue_rd_i (ld_rd),
    .raddr_a_i     (ra),
    .raddr_b_i     (rb),
    .hazard_a_o    (hz_a),
    .hazard_b_o    (hz_b),
    .rf_waddr_o    (waddr),
    .rf_wdata_o    (wdata),
    .rf_we_o       (we),
    .sb_err_o      (err)
`ifdef ARCINO_WB_FWD_EN
    ,
    .fwd_valid_a_o (fv_a),
    .fwd_valid_b_o (fv_b),
    .fwd_data_a_o  (fd_a),
    .fwd_data_b_o  (fd_b)
`endif
  );

  typedef struct {
    logic        av;  reg_addr_t ard; logic [31:0] ad;
    logic        lv;  reg_addr_t lrd; logic [31:0] ld;
    logic        li;  reg_addr_t lird;
    reg_addr_t   ra;  reg_addr_t rb;
    logic        e_ar, e_ha, e_hb;
    logic        e_we; reg_addr_t e_wa; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(
    input logic av, input reg_addr_t ard, input logic [31:0] ad,
    input logic lv, input reg_addr_t lrd, input logic [31:0] ld,
    input logic li, input reg_addr_t lird, input reg_addr_t ra_v, input reg_addr_t rb_v,
    input logic e_ar, input logic e_ha, input logic e_hb,
    input logic e_we, input reg_addr_t e_wa, input logic [31:0] e_wd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.li = li; v.lird = lird; v.ra = ra_v; v.rb = rb_v;
    v.e_ar = e_ar; v.e_ha = e_ha; v.e_hb = e_hb;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_wdata_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_rdata_i = '0;
    ld_issue = 1'b0; ld_rd = '0; ra = '0; rb = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential vectors from reset: comb outputs checked in-cycle, write port after the edge.
    //           ALU valid/rd/data      LSU valid/rd/data      issue   ra  rb    ar  ha  hb   we wa  wd
    tbl[0] = mk(1, 5, 32'hDEADBEEF,  0, 0, 32'h0,   1, 4,   5,  0,   1,  0,  0,   1, 5,  32'hDEADBEEF);
    tbl[1] = mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 0,   5,  4,   1,  NF, 1,   0, 5,  32'hDEADBEEF);
    tbl[2] = mk(1, 3, 32'h11,        1, 4, 32'h22,  0, 0,   5,  4,   0,  0,  1,   1, 4,  32'h22);
    tbl[3] = mk(1, 3, 32'h11,        0, 0, 32'h0,   0, 0,   4,  3,   1,  NF, 0,   1, 3,  32'h11);
    tbl[4] = mk(0, 7, 32'h0,         0, 0, 32'h0,   1, 7,   7,  3,   1,  0,  NF,  0, 3,  32'h11);
    tbl[5] = mk(1, 7, 32'h77,        0, 0, 32'h0,   0, 0,   7,  0,   0,  1,  0,   0, 3,  32'h11);
    tbl[6] = mk(1, 7, 32'h77,        1, 7, 32'h70,  0, 0,   7,  0,   0,  1,  0,   1, 7,  32'h70);
    tbl[7] = mk(1, 7, 32'h77,        0, 0, 32'h0,   0, 0,   7,  0,   1,  NF, 0,   1, 7,  32'h77);
    tbl[8] = mk(1, 0, 32'h99,        0, 0, 32'h0,   0, 0,   7,  0,   1,  NF, 0,   0, 7,  32'h77);

    idle();
    rst = 1'b1;
    step();
    bus.alu_valid_i = 1'b1; bus.lsu_valid_i = 1'b1;
    #1;
    check("rst_alu_ready", {31'd0, bus.alu_ready_o}, 32'd0);
    check("rst_lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd0);
    idle();
    step();
    rst = 1'b0;
    ra = 5'd5;
    #1;
    check("reset_we",    {31'd0, we},  32'd0);
    check("reset_waddr", {27'd0, waddr}, 32'd0);
    check("reset_wdata", wdata, 32'd0);
    check("reset_err",   {31'd0, err}, 32'd0);
    check("reset_hz_a",  {31'd0, hz_a}, 32'd0);
    check("lsu_ready",   {31'd0, bus.lsu_ready_o}, 32'd1);
    step();

    for (int i = 0; i < 9; i++) begin
      bus.alu_valid_i = tbl[i].av; bus.alu_rd_i = tbl[i].ard; bus.alu_wdata_i = tbl[i].ad;
      bus.lsu_valid_i = tbl[i].lv; bus.lsu_rd_i = tbl[i].lrd; bus.lsu_rdata_i = tbl[i].ld;
      ld_issue = tbl[i].li; ld_rd = tbl[i].lird; ra = tbl[i].ra; rb = tbl[i].rb;
      #1;
      check($sformatf("v%0d_alu_ready", i), {31'd0, bus.alu_ready_o}, {31'd0, tbl[i].e_ar});
      check($sformatf("v%0d_lsu_ready", i), {31'd0, bus.lsu_ready_o}, 32'd1);
      check($sformatf("v%0d_hazard_a", i),  {31'd0, hz_a}, {31'd0, tbl[i].e_ha});
      check($sformatf("v%0d_hazard_b", i),  {31'd0, hz_b}, {31'd0, tbl[i].e_hb});
      step();
      check($sformatf("v%0d_we", i),    {31'd0, we}, {31'd0, tbl[i].e_we});
      check($sformatf("v%0d_waddr", i), {27'd0, waddr}, {27'd0, tbl[i].e_wa});
      check($sformatf("v%0d_wdata", i), wdata, tbl[i].e_wd);
      check($sformatf("v%0d_err", i),   {31'd0, err}, 32'd0);
    end

    // Forwarding / one-cycle write-port hazard.
    idle();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd12; bus.alu_wdata_i = 32'h5A;
    step();
    idle();
    rb = 5'd12;
    #1;
    check("fwd_c1_hz_b", {31'd0, hz_b}, {31'd0, NF});
`ifdef ARCINO_WB_FWD_EN
    check("fwd_c1_valid_b", {31'd0, fv_b}, 32'd1);
    check("fwd_c1_data_b",  fd_b, 32'h5A);
    check("fwd_c1_valid_a", {31'd0, fv_a}, 32'd0);
    check("fwd_c1_data_a",  fd_a, 32'd0);
`endif
    step();
    check("fwd_c2_hz_b", {31'd0, hz_b}, 32'd0);

    // Double issue to rd 9 without a response.
    idle();
    ld_issue = 1'b1; ld_rd = 5'd9;
    step();
    check("err_after_first_issue", {31'd0, err}, 32'd0);
    step();
    check("err_after_second_issue", {31'd0, err}, 32'd1);
    idle();
    ra = 5'd9;
    #1;
    check("hz_a_rd9", {31'd0, hz_a}, 32'd1);
    step();
    step();
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset while sb[9] is set and a write is on the port.
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd10; bus.alu_wdata_i = 32'hAB;
    step();
    check("pre_rst_we", {31'd0, we}, 32'd1);
    bus.alu_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_alu_ready", {31'd0, bus.alu_ready_o}, 32'd0);
    check("mid_rst_lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_we",    {31'd0, we}, 32'd0);
    check("post_rst_waddr", {27'd0, waddr}, 32'd0);
    check("post_rst_wdata", wdata, 32'd0);
    check("post_rst_hz_9",  {31'd0, hz_a}, 32'd0);
    check("post_rst_err",   {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
